// File: rtl/instr_register_pkg.sv
// Shared types and constants for the instruction register stack and its ALU.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package instr_register_pkg;

   // Default stack depth; the top-level parameter is overridable but must stay a power of two.
   localparam int DEFAULT_NUM_ENTRIES = 32;

   // Committed-write counter width and its saturation ceiling.
   localparam int WCOUNT_W   = 6;
   localparam logic [WCOUNT_W-1:0] WCOUNT_MAX = '1;

   typedef enum logic [2:0] {
      ZERO  = 3'd0,
      PASSA = 3'd1,
      PASSB = 3'd2,
      ADD   = 3'd3,
      SUB   = 3'd4,
      MULT  = 3'd5,
      DIV   = 3'd6,
      MOD   = 3'd7
   } opcode_t;

   typedef logic signed [31:0] operand_t;
   typedef logic signed [63:0] result_t;

   // One register-stack entry; all-zero decodes as opc=ZERO with zero operands and result.
   typedef struct packed {
      opcode_t  opc;
      operand_t op_a;
      operand_t op_b;
      result_t  result;
   } instruction_t;

   // Widen an operand to result width, preserving sign, so that 64-bit arithmetic
   // cannot overflow (full product, and -2^31 / -1 = +2^31).
   function automatic result_t sext64(input operand_t x);
      return result_t'(x);
   endfunction

endpackage

// File: rtl/instr_alu.sv
// Combinational ALU: opcode and two signed operands to a signed 64-bit result plus divide-by-zero flag.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows inputs every cycle.
module instr_alu
   import instr_register_pkg::*;
(
   input  opcode_t  opc,
   input  operand_t op_a,
   input  operand_t op_b,
   output result_t  result,
   output logic     div_zero
);

   result_t a64;
   result_t b64;
   logic    b_is_zero;

   assign a64       = sext64(op_a);
   assign b64       = sext64(op_b);
   assign b_is_zero = (op_b == '0);

   // Select the operation; DIV/MOD by zero return 0 and raise the flag instead of dividing.
   always_comb begin
      result   = '0;
      div_zero = 1'b0;
      case (opc)
         ZERO:  result = '0;
         PASSA: result = a64;
         PASSB: result = b64;
         ADD:   result = a64 + b64;
         SUB:   result = a64 - b64;
         MULT:  result = a64 * b64;
         DIV: begin
            if (b_is_zero) begin
               div_zero = 1'b1;
            end else begin
               // Signed '/' truncates toward zero.
               result = a64 / b64;
            end
         end
         MOD: begin
            if (b_is_zero) begin
               div_zero = 1'b1;
            end else begin
               // Signed '%' takes the sign of the dividend.
               result = a64 % b64;
            end
         end
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/instr_register_alu.sv
// Instruction register stack: captures writes, computes results in a commit stage, serves a registered read port.
// Latency: write commits one cycle after capture; read data appears one cycle after read_pointer is sampled (write-first bypass).
// Backpressure: none; accepts one write and serves one read every cycle.
module instr_register_alu
   import instr_register_pkg::*;
#(
   parameter int NUM_ENTRIES = DEFAULT_NUM_ENTRIES,
   parameter int PTR_W       = $clog2(NUM_ENTRIES)
)
(
   input  logic                clk,
   input  logic                reset_n,
   input  logic                load_en,
   input  logic [PTR_W-1:0]    write_pointer,
   input  opcode_t             opcode,
   input  operand_t            operand_a,
   input  operand_t            operand_b,
   input  logic [PTR_W-1:0]    read_pointer,
   output instruction_t        instruction_word,
   output logic                rd_valid,
   output logic                rd_err,
   output logic [WCOUNT_W-1:0] write_count
);

   // Stage 1: captured write request awaiting commit.
   logic             s1_vld;
   logic [PTR_W-1:0] s1_ptr;
   opcode_t          s1_opc;
   operand_t         s1_a;
   operand_t         s1_b;

   // Stage 2: ALU outputs and the entry that will be written on the next edge.
   result_t          alu_result;
   logic             alu_div_zero;
   instruction_t     commit_word;

   // Register stack with per-entry committed and divide-by-zero flags.
   instruction_t     entry_mem [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] entry_vld;
   logic [NUM_ENTRIES-1:0] entry_err;

   // Read and commit targeting the same entry on the same edge.
   logic             bypass_hit;

   // Capture a write request; a cycle without load_en leaves stage 1 empty.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_vld <= 1'b0;
         s1_ptr <= '0;
         s1_opc <= ZERO;
         s1_a   <= '0;
         s1_b   <= '0;
      end else begin
         s1_vld <= load_en;
         if (load_en) begin
            s1_ptr <= write_pointer;
            s1_opc <= opcode;
            s1_a   <= operand_a;
            s1_b   <= operand_b;
         end
      end
   end

   instr_alu u_alu (
      .opc      (s1_opc),
      .op_a     (s1_a),
      .op_b     (s1_b),
      .result   (alu_result),
      .div_zero (alu_div_zero)
   );

   assign commit_word.opc    = s1_opc;
   assign commit_word.op_a   = s1_a;
   assign commit_word.op_b   = s1_b;
   assign commit_word.result = alu_result;

   // Commit the computed entry; an overwrite replaces every field and recomputes err.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            entry_mem[i] <= '0;
         end
         entry_vld <= '0;
         entry_err <= '0;
      end else if (s1_vld) begin
         entry_mem[s1_ptr] <= commit_word;
         entry_vld[s1_ptr] <= 1'b1;
         entry_err[s1_ptr] <= alu_div_zero;
      end
   end

   // Count committed writes, holding at the counter's maximum.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         write_count <= '0;
      end else if (s1_vld && (write_count != WCOUNT_MAX)) begin
         write_count <= write_count + 1'b1;
      end
   end

   assign bypass_hit = s1_vld && (s1_ptr == read_pointer);

   // Registered read port; a same-edge commit to the addressed entry is returned directly.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         instruction_word <= '0;
         rd_valid         <= 1'b0;
         rd_err           <= 1'b0;
      end else if (bypass_hit) begin
         instruction_word <= commit_word;
         rd_valid         <= 1'b1;
         rd_err           <= alu_div_zero;
      end else begin
         instruction_word <= entry_mem[read_pointer];
         rd_valid         <= entry_vld[read_pointer];
         rd_err           <= entry_err[read_pointer];
      end
   end

endmodule

// File: tb/tb_instr_register_alu.sv
// Self-checking bench for instr_register_alu: directed cases then randomized traffic against a reference model.
// Driver pushes the expected read response per clock edge; a monitor pops and compares after each edge.
// Reset cycles are checked against the all-zero reset state.
module tb_instr_register_alu;
   import instr_register_pkg::*;

   localparam int N  = 32;
   localparam int PW = 5;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         load_en = 1'b0;
   logic [PW-1:0] write_pointer = '0;
   opcode_t      opcode = ZERO;
   operand_t     operand_a = '0;
   operand_t     operand_b = '0;
   logic [PW-1:0] read_pointer = '0;
   instruction_t instruction_word;
   logic         rd_valid;
   logic         rd_err;
   logic [5:0]   write_count;

   always #5 clk = ~clk;

   instr_register_alu #(.NUM_ENTRIES(N), .PTR_W(PW)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .load_en          (load_en),
      .write_pointer    (write_pointer),
      .opcode           (opcode),
      .operand_a        (operand_a),
      .operand_b        (operand_b),
      .read_pointer     (read_pointer),
      .instruction_word (instruction_word),
      .rd_valid         (rd_valid),
      .rd_err           (rd_err),
      .write_count      (write_count)
   );

   // Reference model: contents of the stack as seen by software, plus the one write in flight.
   instruction_t m_word [N];
   bit           m_vld  [N];
   bit           m_err  [N];
   int           m_cnt;
   bit           p_vld;
   int           p_ptr;
   opcode_t      p_opc;
   operand_t     p_a;
   operand_t     p_b;

   typedef struct {
      instruction_t word;
      bit           vld;
      bit           err;
      int           cnt;
   } exp_t;

   exp_t sb [$];
   exp_t mon_e;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [130:0] act, input logic [130:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
      end
   endtask

   // Arithmetic from first principles: division via magnitudes, remainder from a = q*b + r.
   task automatic ref_alu(input opcode_t op, input longint a, input longint b,
                          output longint r, output bit e);
      longint ma, mb, q;
      r = 0;
      e = 1'b0;
      case (op)
         ZERO:  r = 0;
         PASSA: r = a;
         PASSB: r = b;
         ADD:   r = a + b;
         SUB:   r = a - b;
         MULT:  r = a * b;
         default: begin
            if (b == 0) begin
               e = 1'b1;
            end else begin
               ma = (a < 0) ? -a : a;
               mb = (b < 0) ? -b : b;
               q  = ma / mb;
               if ((a < 0) != (b < 0)) q = -q;
               r  = (op == DIV) ? q : (a - q * b);
            end
         end
      endcase
   endtask

   function automatic void model_clear();
      for (int i = 0; i < N; i++) begin
         m_word[i] = '0;
         m_vld[i]  = 1'b0;
         m_err[i]  = 1'b0;
      end
      m_cnt = 0;
      p_vld = 1'b0;
   endfunction

   // One clock of stimulus; predicts what the read port shows after the coming edge.
   task automatic cycle(input bit le, input int wp, input opcode_t op,
                        input int a, input int b, input int rp);
      longint r;
      bit     e;
      exp_t   x;
      @(negedge clk);
      load_en       = le;
      write_pointer = PW'(wp % N);
      opcode        = op;
      operand_a     = a;
      operand_b     = b;
      read_pointer  = PW'(rp % N);
      if (p_vld) begin
         ref_alu(p_opc, p_a, p_b, r, e);
         m_word[p_ptr].opc    = p_opc;
         m_word[p_ptr].op_a   = p_a;
         m_word[p_ptr].op_b   = p_b;
         m_word[p_ptr].result = r;
         m_vld[p_ptr] = 1'b1;
         m_err[p_ptr] = e;
         if (m_cnt < 63) m_cnt++;
      end
      x.word = m_word[rp % N];
      x.vld  = m_vld[rp % N];
      x.err  = m_err[rp % N];
      x.cnt  = m_cnt;
      sb.push_back(x);
      p_vld = le;
      p_ptr = wp % N;
      p_opc = op;
      p_a   = a;
      p_b   = b;
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      reset_n = 1'b0;
      load_en = 1'b0;
      sb.delete();
      model_clear();
      repeat (cycles) @(negedge clk);
      reset_n = 1'b1;
   endtask

   function automatic int pick();
      int v;
      case ($urandom_range(0, 5))
         0: v = 0;
         1: v = -1;
         2: v = 32'h8000_0000;
         3: v = int'($urandom_range(0, 20)) - 10;
         default: v = int'($urandom);
      endcase
      return v;
   endfunction

   // Monitor: after every edge, reset state while in reset, otherwise the oldest prediction.
   always @(posedge clk) begin
      #1;
      if (!reset_n) begin
         chk("reset_word",  instruction_word, '0);
         chk("reset_valid", 131'(rd_valid), '0);
         chk("reset_err",   131'(rd_err), '0);
         chk("reset_count", 131'(write_count), '0);
      end else if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         chk("word",  instruction_word, mon_e.word);
         chk("valid", 131'(rd_valid), 131'(mon_e.vld));
         chk("err",   131'(rd_err), 131'(mon_e.err));
         chk("count", 131'(write_count), 131'(mon_e.cnt));
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int imin;
      int last_wp;
      imin = 32'h8000_0000;
      model_clear();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // Unwritten entries after reset.
      cycle(0, 0, ZERO, 0, 0, 0);
      cycle(0, 0, ZERO, 0, 0, 31);
      cycle(0, 0, ZERO, 0, 0, 15);

      // Basic back-to-back writes and readback.
      cycle(1, 0, ADD,   7,  -3, 0);
      cycle(1, 1, MULT, -15, 15, 1);
      cycle(1, 2, SUB,   0,   9, 0);
      cycle(0, 0, ZERO,  0,   0, 1);
      cycle(0, 0, ZERO,  0,   0, 2);
      cycle(0, 0, ZERO,  0,   0, 0);

      // Division rules, error overwrite, and the -2^31 / -1 case.
      cycle(1, 8,  DIV,  -7, 2, 0);
      cycle(1, 9,  MOD,  -7, 2, 8);
      cycle(1, 10, DIV,   5, 0, 9);
      cycle(0, 0,  ZERO,  0, 0, 10);
      cycle(1, 10, PASSA, 5, 0, 10);
      cycle(0, 0,  ZERO,  0, 0, 10);
      cycle(1, 11, DIV, imin, -1, 10);
      cycle(1, 12, MOD, imin, -1, 11);
      cycle(0, 0,  ZERO,  0, 0, 11);
      cycle(0, 0,  ZERO,  0, 0, 12);

      // Same-edge read of the entry being committed.
      cycle(1, 4, PASSB, 0, 12, 0);
      cycle(0, 0, ZERO,  0, 0, 4);

      // Same entry written on consecutive cycles: last wins.
      cycle(1, 5, PASSA, 1, 0, 0);
      cycle(1, 5, PASSA, 2, 0, 5);
      cycle(0, 0, ZERO,  0, 0, 5);

      // Reset while a write is still in stage 1.
      cycle(1, 6, ADD, 1, 2, 0);
      do_reset(2);
      cycle(0, 0, ZERO, 0, 0, 6);
      cycle(0, 0, ZERO, 0, 0, 6);

      // Full sweep twice; the counter saturates.
      for (int i = 0; i < N; i++) cycle(1, i, PASSA, i, 0, 0);
      for (int i = 0; i < N; i++) cycle(1, i, PASSA, i + 100, 0, i);
      for (int i = 0; i < N; i++) cycle(0, 0, ZERO, 0, 0, i);

      // Randomized traffic with frequent bypass collisions.
      do_reset(1);
      last_wp = 0;
      for (int k = 0; k < 400; k++) begin
         int wp;
         int rp;
         wp = int'($urandom_range(0, N - 1));
         rp = ($urandom_range(0, 2) == 0) ? last_wp : int'($urandom_range(0, N - 1));
         cycle($urandom_range(0, 3) != 0, wp, opcode_t'($urandom_range(0, 7)), pick(), pick(), rp);
         last_wp = wp;
      end

      cycle(0, 0, ZERO, 0, 0, 0);
      cycle(0, 0, ZERO, 0, 0, last_wp);
      repeat (2) @(negedge clk);
      chk("scoreboard_drained", 131'(sb.size()), '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instr_register_alu.md
# instr_register_alu

Responder side of the instruction-register interface. It accepts instruction writes (opcode plus two signed operands) into a 32-entry register stack. A pipelined ALU computes each entry's result before the entry is committed. Any entry can be read back through a registered read port. It is the DUT that the instruction-register testbenches drive through the shared test interface.

## Interface
Parameters:
- NUM_ENTRIES, 32: register stack depth; must be a power of two.
- PTR_W, 5: pointer width, equal to $clog2(NUM_ENTRIES).

Ports (clock and reset first):
- clk  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  reset, asynchronous and active-low.
- load_en  input  1  write request, sampled at posedge clk.
- write_pointer  input  PTR_W  destination entry for the write.
- opcode  input  opcode_t  operation code.
- operand_a  input  operand_t  signed 32-bit operand.
- operand_b  input  operand_t  signed 32-bit operand.
- read_pointer  input  PTR_W  entry to read, sampled every posedge.
- instruction_word  output  instruction_t  registered read data: opc, op_a, op_b, result.
- rd_valid  output  1  read entry has been committed since reset.
- rd_err  output  1  read entry was a DIV or MOD with op_b == 0.
- write_count  output  6  number of committed writes, saturating at 63.

## Operation
- Stage 1 (capture): when load_en=1 at posedge N, register {write_pointer, opcode, operand_a, operand_b} and set the stage-1 valid bit.
  - load_en=0 clears the stage-1 valid bit.
  - A write can be captured every cycle; no stall.
- Stage 2 (commit): at posedge N+1, if stage-1 is valid:
  - compute the result and write {opc, op_a, op_b, result} into entry[ptr];
  - set valid[ptr] and set err[ptr] to the divide-by-zero flag;
  - increment write_count.
- Arithmetic (result is signed 64-bit; operands are sign-extended):
  - ZERO → 0; PASSA → op_a; PASSB → op_b; ADD → a+b; SUB → a−b; MULT → full 64-bit product.
  - DIV truncates toward zero. MOD takes the sign of the dividend.
  - DIV or MOD with op_b=0 → result 0 and err=1.
  - The −2^31 / −1 case gives +2^31 with no error.
- Overwriting an entry replaces all fields. err is recomputed on every overwrite.
- Read port: at every posedge, instruction_word, rd_valid and rd_err load entry[read_pointer], valid[read_pointer] and err[read_pointer].
- Read/commit collision: if the read and a commit hit the same entry on the same edge, the read returns the newly committed data (write-first bypass).
- Reset (asynchronous, reset_n=0):
  - all entries, valid and err bits cleared; stage-1 valid cleared;
  - instruction_word = 0 (opc=ZERO), rd_valid=0, rd_err=0, write_count=0.
  - A write in flight in stage 1 is discarded.
- Pointer wrap: pointers are exactly PTR_W bits wide, so no out-of-range access is possible.

## Timing
- Write latency: load_en at posedge N → entry committed at posedge N+1 → readable in instruction_word after posedge N+2. With the bypass, it is readable after N+1 if read_pointer addresses the entry at N+1.
- Read latency: one cycle. read_pointer sampled at posedge M → output valid after M, stable until M+1. This is safe for sampling at negedge M.
- Back-to-back writes to the same entry on consecutive cycles: the last one wins. write_count increments for both.
- Throughput: one write and one read per cycle.
- reset_n deassertion is synchronised by the system. The first capture occurs at the first posedge with reset_n=1.

## Structure
- instr_register_pkg holds the shared types and constants:
  - opcode_t enum: ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD = 0..7;
  - operand_t as signed 32-bit and result_t as signed 64-bit;
  - instruction_t packed struct {opc, op_a, op_b, result};
  - NUM_ENTRIES default.
- One sub-module, instr_alu: combinational opcode/operand → {result, div_zero}. It is instantiated in stage 2.

## Test plan
- Reset check: hold reset_n=0 for 2 cycles, then read entries 0, 31 and 15 → instruction_word=0, rd_valid=0, write_count=0.
- Write/read basic: write entry 0 = ADD(7, −3), entry 1 = MULT(−15, 15), entry 2 = SUB(0, 9) on consecutive cycles.
  - Read back → results 4, −225, −9; rd_valid=1; rd_err=0; write_count=3.
- Division rules: DIV(−7, 2) → −3; MOD(−7, 2) → −1; DIV(5, 0) → result 0, rd_err=1.
  - Then overwrite the same entry with PASSA(5, 0) → rd_err=0, result 5.
- Collision bypass: load_en at posedge N to entry 4 = PASSB(0, 12), with read_pointer=4 at posedge N+1 → instruction_word.result=12 after N+1.
- Mid-operation reset: assert reset_n one cycle after load_en to entry 6, before commit.
  - After release, read entry 6 → rd_valid=0, write_count=0.
- Saturation and full sweep: write all 32 entries twice, with PASSA(i) then PASSA(i+100).
  - write_count=63 (saturated); each entry i reads i+100.
